rom_loader: RTL

//  Boot-time image copier: streams N ROM images into external RAM before the core runs.

---
 rtl/rom_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader: boot-time image copier.
// Walks a flat byte pointer over SLOTS slots of 2^SLOTW bytes each. Every byte
// is fetched from the selected ROM image (or replaced by FILL past the image
// length / for slots with no image) and written to RAM through a stallable
// request/acknowledge port. Raises init when every slot has been written and
// restarts from address 0 on reload.
module rom_loader #(
    parameter int unsigned SLOTW   = 15,
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned IMAGES  = 3,
    parameter logic [IMAGES*(SLOTW+1)-1:0] LENS = {3{16'h8000}},
    parameter int unsigned ROM_LAT = 1,
    parameter logic [7:0]  FILL    = 8'hFF,
    localparam int unsigned SELW   = (IMAGES > 1) ? $clog2(IMAGES) : 1,
    localparam int unsigned AW     = SLOTW + $clog2(SLOTS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            reload,
    output logic [SELW-1:0] romSel,
    output logic [SLOTW-1:0] romA,
    input  logic [7:0]      romQ,
    output logic            memW,
    input  logic            memAck,
    output logic [AW-1:0]   memA,
    output logic [7:0]      memD,
    output logic            busy,
    output logic            init
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned    LW       = SLOTW + 1;
    localparam logic [AW-1:0]  PTR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [2:0]     LAT_LAST = 3'(ROM_LAT);

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            memw_q, memw_d;
    logic [7:0]      memd_q, memd_d;
    logic            reload_pend_q, reload_pend_d;

    int unsigned     slot;
    logic [SLOTW-1:0] offset;
    logic [LW-1:0]   slot_len;
    logic            is_fill;

    // Decode the pointer into slot/offset and decide whether this byte is padding.
    always_comb begin
        slot     = 32'(ptr_q) >> SLOTW;
        offset   = ptr_q[SLOTW-1:0];
        slot_len = '0;
        for (int unsigned i = 0; i < IMAGES; i++) begin
            if (slot == i) slot_len = LENS[i*LW +: LW];
        end
        is_fill = (slot >= IMAGES) || ({1'b0, offset} >= slot_len);
    end

    // The ROM and RAM addresses come straight from the pointer register, so
    // they are stable for the whole fetch and the whole write handshake.
    assign romSel = SELW'(slot);
    assign romA   = offset;
    assign memA   = ptr_q;
    assign memW   = memw_q;
    assign memD   = memd_q;
    assign busy   = (state_q == FETCH) || (state_q == WRITE);
    assign init   = (state_q == DONE);

    // Next-state logic: fetch wait, write handshake, pause on start low, reload restart.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        memw_d        = memw_q;
        memd_d        = memd_q;
        reload_pend_d = reload_pend_q;

        unique case (state_q)
            IDLE: begin
                ptr_d = '0;
                cnt_d = '0;
                if (start && !reload) state_d = FETCH;
            end

            FETCH: begin
                if (reload) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else if (start) begin
                    if (is_fill) begin
                        // Padding bytes never wait for the ROM.
                        memd_d  = FILL;
                        memw_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else if (cnt_q == LAT_LAST) begin
                        // romQ now reflects the address driven since entry.
                        memd_d  = romQ;
                        memw_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            WRITE: begin
                if (memAck) begin
                    memw_d        = 1'b0;
                    reload_pend_d = 1'b0;
                    if (reload || reload_pend_q) begin
                        // The accepted write counts, but the copy restarts at 0.
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else if (ptr_q == PTR_LAST) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + PTR_ONE;
                        state_d = FETCH;
                    end
                end else if (reload) begin
                    // An outstanding request is never withdrawn; remember the restart.
                    reload_pend_d = 1'b1;
                end
            end

            DONE: begin
                if (reload) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            memw_q        <= 1'b0;
            memd_q        <= FILL;
            reload_pend_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            memw_q        <= memw_d;
            memd_q        <= memd_d;
            reload_pend_q <= reload_pend_d;
        end
    end

endmodule
